// File: rtl/mitchell_divider.sv
// Iterative Mitchell-approximation unsigned divider: serial normalization, log-domain subtract, linear antilog.
// Define MITCHELL_DIV_ROUND_EN to round the final right shift half-up instead of truncating it.
module mitchell_divider #(
    parameter int BIT_WIDTH = 24,
    parameter int FRAC_BITS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BIT_WIDTH-1:0]           dividend,
    input  logic [BIT_WIDTH-1:0]           divisor,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIT_WIDTH+FRAC_BITS-1:0] quotient,
    output logic                           div_by_zero
);

    localparam int W   = BIT_WIDTH;
    localparam int OW  = BIT_WIDTH + FRAC_BITS;
    localparam int LZW = $clog2(BIT_WIDTH) + 1;
    localparam logic [LZW-1:0] LZ_ONE = {{(LZW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [LZW-1:0]  lz_a_q, lz_a_d;
    logic [LZW-1:0]  lz_b_q, lz_b_d;
    logic [OW-1:0]   quotient_q, quotient_d;
    logic            dbz_q, dbz_d;

    logic [W-2:0]    frac_diff;
    logic            borrow;
    logic [W-1:0]    mant;
    int              exp_val;
    int              shift_val;
    logic [31:0]     shamt;
    logic [OW-1:0]   mant_ext;
    logic [OW-1:0]   round_add;
    logic [OW-1:0]   calc_q;

    // Log-domain subtraction of the normalized operands followed by the piecewise-linear antilog.
    always_comb begin
        frac_diff = a_q[W-2:0] - b_q[W-2:0];
        borrow    = (a_q[W-2:0] < b_q[W-2:0]);
        mant      = {1'b1, frac_diff};
        exp_val   = int'(lz_b_q) - int'(lz_a_q) - int'(borrow);
        shift_val = exp_val + FRAC_BITS - (W - 1);
        mant_ext  = {{(OW-W){1'b0}}, mant};
        round_add = '0;
        shamt     = '0;
        calc_q    = '0;
        if (shift_val >= 0) begin
            shamt  = $unsigned(shift_val);
            calc_q = mant_ext << shamt;
        end else begin
            shamt  = $unsigned(-shift_val);
`ifdef MITCHELL_DIV_ROUND_EN
            round_add = {{(OW-1){1'b0}}, 1'b1} << (shamt - 32'd1);
`else
            round_add = '0;
`endif
            calc_q = (mant_ext + round_add) >> shamt;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        lz_a_d     = lz_a_q;
        lz_b_d     = lz_b_q;
        quotient_d = quotient_q;
        dbz_d      = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = dividend;
                    b_d    = divisor;
                    lz_a_d = '0;
                    lz_b_d = '0;
                    if (divisor == '0) begin
                        quotient_d = '1;
                        dbz_d      = 1'b1;
                        state_d    = DONE;
                    end else if (dividend == '0) begin
                        quotient_d = '0;
                        dbz_d      = 1'b0;
                        state_d    = DONE;
                    end else if (dividend[W-1] && divisor[W-1]) begin
                        state_d = CALC;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            // Leaves on the same edge that completes normalization, so NORM lasts max(lz_a, lz_b) cycles.
            NORM: begin
                if (!a_q[W-1]) begin
                    a_d    = a_q << 1;
                    lz_a_d = lz_a_q + LZ_ONE;
                end
                if (!b_q[W-1]) begin
                    b_d    = b_q << 1;
                    lz_b_d = lz_b_q + LZ_ONE;
                end
                if (a_d[W-1] && b_d[W-1]) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                quotient_d = calc_q;
                dbz_d      = 1'b0;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            lz_a_q     <= '0;
            lz_b_q     <= '0;
            quotient_q <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            lz_a_q     <= lz_a_d;
            lz_b_q     <= lz_b_d;
            quotient_q <= quotient_d;
            dbz_q      <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign div_by_zero = dbz_q;

endmodule
